block_raster_streamer: RTL and testbench
========================================

Name: block_raster_streamer

Overview:
- Sink-side consumer of the decoder's colour output interface: captures each 8x8 RGB block on the `valid_out_Color` pulse and streams it out one pixel per cycle.
- Each pixel carries its absolute image coordinate, computed from the decoder's 4:2:0 MCU block order.
- It sits between `top` and any frame writer, display or DMA, and replaces the bench-side block dump.
- The decoder has no backpressure on its colour output, so the block double-buffers and flags overruns.

Parameters:
- COORD_W, 16, width of the pixel x/y coordinate outputs.
- DIM_W, 8, width of the block-count configuration inputs.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- blocks_wide  in  DIM_W  image width in 8x8 blocks; always even (ceil(W/16)*2); held stable for a whole frame
- blocks_tall  in  DIM_W  image height in 8x8 blocks; always even
- r, g, b  in  8x8x8  unsigned block samples, indexed [row][col]
- valid_in  in  1  one-cycle block strobe; connects to `valid_out_Color`
- space_avail  out  1  at least one block buffer is free; used to gate the decoder's request
- px_r, px_g, px_b  out  8  pixel samples
- px_x, px_y  out  COORD_W  absolute pixel coordinate
- px_valid  out  1  pixel output valid
- px_ready  in  1  downstream accepts the pixel
- frame_done  out  1  one-cycle pulse coincident with the last pixel handshake of a frame
- overflow  out  1  sticky: a block was dropped

Behaviour:
- Reset (rst=0 at posedge):
  - Both buffers invalidated; all counters cleared.
  - px_valid=0, frame_done=0, overflow=0, space_avail=1.
  - px_* data and coordinates = 0.
  - Reset mid-block discards all buffered data.
- Buffering:
  - Two 64-entry RGB block buffers, used in ping-pong order.
  - wr_sel and rd_sel toggle on each capture and each drain, respectively.
  - `occ` (0..2) tracks buffer occupancy.
- Capture:
  - On valid_in=1 with occ<2, the whole block is latched into buf[wr_sel] in that same cycle.
  - That buffer is tagged with the current block index, and the block index is incremented.
- Simultaneous capture and release:
  - If valid_in=1, occ==2, and the last pixel of the read buffer handshakes in the same cycle, the block is accepted into the freed buffer.
  - occ stays 2.
- Overflow:
  - valid_in=1 with occ==2 and no same-cycle release: the block is dropped and overflow is set.
  - The block index is still incremented, so later coordinates stay correct.
- Latency: px_valid rises the cycle after capture when the stream is idle (occ was 0).
- Output state machine:
  - IDLE -> STREAM when occ>0.
  - STREAM: pixel counter p=0..63, i=p[5:3] (row), j=p[2:0] (col).
  - Advances only on px_valid && px_ready.
  - At p=63 handshake: go to STREAM if the other buffer is valid, else IDLE.
  - No bubble between blocks.
- Output stability: px_* outputs hold stable while px_valid && !px_ready (AXI-style; px_valid never drops without a handshake).
- Coordinate mapping, for block index k:
  - sub = k[1:0], mcu = k>>2, mcus_wide = blocks_wide/2.
  - mcu_x = mcu mod mcus_wide, mcu_y = mcu / mcus_wide.
  - Track mcu_x/mcu_y with wrap counters; no dividers.
  - x0 = 16*mcu_x + 8*sub[0], y0 = 16*mcu_y + 8*sub[1].
  - px_x = x0+j, px_y = y0+i.
- Frame boundary:
  - Frame size = blocks_wide*blocks_tall blocks.
  - frame_done pulses on the handshake of pixel 63 of block index frame_size-1.
  - The capture-side block index wraps to 0 when it reaches frame_size; the next frame's blocks restart at coordinate (0,0).
- Zero dimensions: blocks_wide==0 or blocks_tall==0 gives undefined coordinates; the bench does not drive this.
- space_avail = (occ<2) as a registered-state decode, not a function of the same-cycle valid_in.

Decomposition:
- Shared package (existing codebase package):
  - BLOCK_DIM=8 and MCU_DIM=16 constants.
  - A `RGB_BLOCK` typedef (three 8x8x8 arrays).
  - A `PIXEL_PACKET` typedef {r,g,b,x,y}.
- One natural sub-module: `mcu_coord_gen`.
  - Holds the block index, sub, and mcu_x/mcu_y wrap counters.
  - Produces the per-buffer origin (x0,y0).
  - Raises a last-block-of-frame flag.

Test Plan:
- Single block, blocks_wide=2, blocks_tall=2, px_ready=1, r[i][j]=8i+j:
  - 64 pixels on consecutive cycles starting 1 cycle after valid_in.
  - px_x=j, px_y=i, px_r=8i+j.
- 16x16 frame (4 blocks), each block tagged with a constant value:
  - Origins (0,0), (8,0), (0,8), (8,8).
  - frame_done pulses once, on pixel (15,15).
- blocks_wide=4, blocks_tall=2, 8 blocks:
  - Block 4 origin (16,0); block 7 origin (24,8).
  - Next frame's block 0 returns to (0,0).
- px_ready held 0 while 3 blocks are strobed 10 cycles apart:
  - Blocks 1 and 2 are buffered; space_avail=0 after block 2.
  - Block 3 is dropped and overflow=1 stays set.
  - Releasing px_ready yields 128 pixels, and the coordinates of later blocks skip the dropped index.
- Random px_ready stalls: px_* stay stable during stalls; no pixel is lost or duplicated (scoreboard check).
- valid_in on the same cycle as pixel 63 of a full buffer: block accepted, overflow stays 0.
- Reset asserted mid-stream: next cycle px_valid=0, occ=0, and the next frame starts at (0,0).

Source files
------------

// File: rtl/block_raster_streamer_pkg.sv
// Shared types and constants for the colour-block raster streamer.
package block_raster_streamer_pkg;
  localparam int BLOCK_DIM   = 8;
  localparam int MCU_DIM     = 16;
  localparam int PIX_W       = 8;
  localparam int PKT_COORD_W = 16;

  typedef logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][PIX_W-1:0] chan_blk_t;

  typedef struct packed {
    chan_blk_t r;
    chan_blk_t g;
    chan_blk_t b;
  } RGB_BLOCK;

  typedef struct packed {
    logic [PIX_W-1:0]       r;
    logic [PIX_W-1:0]       g;
    logic [PIX_W-1:0]       b;
    logic [PKT_COORD_W-1:0] x;
    logic [PKT_COORD_W-1:0] y;
  } PIXEL_PACKET;

  typedef enum logic {ST_IDLE, ST_STREAM} out_state_e;
endpackage

// File: rtl/block_raster_streamer_if.sv
// Pixel stream leaving the streamer: valid/ready handshake plus frame marker.
interface block_raster_streamer_if #(
  parameter int COORD_W = 16
);
  logic [7:0]         px_r;
  logic [7:0]         px_g;
  logic [7:0]         px_b;
  logic [COORD_W-1:0] px_x;
  logic [COORD_W-1:0] px_y;
  logic               px_valid;
  logic               px_ready;
  logic               frame_done;

  modport master (
    output px_r, px_g, px_b, px_x, px_y, px_valid, frame_done,
    input  px_ready
  );

  modport slave (
    input  px_r, px_g, px_b, px_x, px_y, px_valid, frame_done,
    output px_ready
  );
endinterface

// File: rtl/block_raster_streamer_mcu_coord_gen.sv
// Tracks the 4:2:0 block index as sub-block plus MCU wrap counters and
// emits the pixel origin of the current block and a last-of-frame flag.
module mcu_coord_gen
  import block_raster_streamer_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int DIM_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIM_W-1:0]   blocks_wide,
  input  logic [DIM_W-1:0]   blocks_tall,
  input  logic               advance,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic               last_blk
);
  logic [1:0]       sub_q, sub_d;
  logic [DIM_W-1:0] mcu_x_q, mcu_x_d;
  logic [DIM_W-1:0] mcu_y_q, mcu_y_d;
  logic [DIM_W-1:0] mcus_wide_m1, mcus_tall_m1;
  logic             col_end, row_end;

  always_comb begin
    mcus_wide_m1 = (blocks_wide >> 1) - DIM_W'(1);
    mcus_tall_m1 = (blocks_tall >> 1) - DIM_W'(1);
    col_end      = (mcu_x_q == mcus_wide_m1);
    row_end      = (mcu_y_q == mcus_tall_m1);
    last_blk     = (sub_q == 2'd3) && col_end && row_end;
    // 16*mcu + 8*sub_bit is just a bit concatenation
    x0 = COORD_W'({mcu_x_q, sub_q[0], 3'b000});
    y0 = COORD_W'({mcu_y_q, sub_q[1], 3'b000});

    sub_d   = sub_q;
    mcu_x_d = mcu_x_q;
    mcu_y_d = mcu_y_q;
    if (advance) begin
      if (sub_q != 2'd3) begin
        sub_d = sub_q + 2'd1;
      end else begin
        sub_d = 2'd0;
        if (col_end) begin
          mcu_x_d = '0;
          mcu_y_d = row_end ? '0 : mcu_y_q + DIM_W'(1);
        end else begin
          mcu_x_d = mcu_x_q + DIM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sub_q   <= '0;
      mcu_x_q <= '0;
      mcu_y_q <= '0;
    end else begin
      sub_q   <= sub_d;
      mcu_x_q <= mcu_x_d;
      mcu_y_q <= mcu_y_d;
    end
  end
endmodule

// File: rtl/block_raster_streamer.sv
// Captures 8x8 RGB blocks into a ping-pong buffer pair and streams them out
// one pixel per handshake with absolute image coordinates.
module block_raster_streamer
  import block_raster_streamer_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int DIM_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIM_W-1:0]         blocks_wide,
  input  logic [DIM_W-1:0]         blocks_tall,
  input  chan_blk_t                r,
  input  chan_blk_t                g,
  input  chan_blk_t                b,
  input  logic                     valid_in,
  output logic                     space_avail,
  output logic                     overflow,
  block_raster_streamer_if.master  px_if
);
  RGB_BLOCK           buf_q [2], buf_d [2];
  logic [COORD_W-1:0] x0_q [2], x0_d [2];
  logic [COORD_W-1:0] y0_q [2], y0_d [2];
  logic               last_q [2], last_d [2];
  logic [1:0]         occ_q, occ_d;
  logic               wr_sel_q, wr_sel_d;
  logic               rd_sel_q, rd_sel_d;
  logic [5:0]         p_q, p_d;
  logic               overflow_q, overflow_d;
  out_state_e         state_q, state_d;

  logic               px_valid, hs, release_blk, capture;
  logic [COORD_W-1:0] cg_x0, cg_y0;
  logic               cg_last;
  RGB_BLOCK           rd_blk;
  logic [2:0]         row, col;

  // Dropped blocks still advance the index so later origins stay aligned.
  mcu_coord_gen #(.COORD_W(COORD_W), .DIM_W(DIM_W)) u_coord (
    .clk         (clk),
    .rst         (rst),
    .blocks_wide (blocks_wide),
    .blocks_tall (blocks_tall),
    .advance     (valid_in),
    .x0          (cg_x0),
    .y0          (cg_y0),
    .last_blk    (cg_last)
  );

  always_comb begin
    px_valid    = (state_q == ST_STREAM);
    hs          = px_valid && px_if.px_ready;
    release_blk = hs && (p_q == 6'd63);
    // When full, wr_sel points at the buffer being drained, so a same-cycle
    // release lets the incoming block land there.
    capture     = valid_in && ((occ_q != 2'd2) || release_blk);

    buf_d      = buf_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    last_d     = last_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    p_d        = p_q;
    occ_d      = occ_q;
    overflow_d = overflow_q || (valid_in && !capture);
    state_d    = state_q;

    if (capture) begin
      buf_d[wr_sel_q]  = RGB_BLOCK'({r, g, b});
      x0_d[wr_sel_q]   = cg_x0;
      y0_d[wr_sel_q]   = cg_y0;
      last_d[wr_sel_q] = cg_last;
      wr_sel_d         = !wr_sel_q;
    end
    if (hs)          p_d      = p_q + 6'd1;
    if (release_blk) rd_sel_d = !rd_sel_q;

    if (capture && !release_blk)      occ_d = occ_q + 2'd1;
    else if (!capture && release_blk) occ_d = occ_q - 2'd1;

    case (state_q)
      ST_IDLE:   if (occ_d != 2'd0) state_d = ST_STREAM;
      ST_STREAM: if (release_blk && (occ_d == 2'd0)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_blk = buf_q[rd_sel_q];
    row    = p_q[5:3];
    col    = p_q[2:0];
    // Data is forced to zero outside a valid beat so reset needs no buffer clear.
    px_if.px_valid   = px_valid;
    px_if.px_r       = px_valid ? rd_blk.r[row][col] : '0;
    px_if.px_g       = px_valid ? rd_blk.g[row][col] : '0;
    px_if.px_b       = px_valid ? rd_blk.b[row][col] : '0;
    px_if.px_x       = px_valid ? x0_q[rd_sel_q] + COORD_W'(col) : '0;
    px_if.px_y       = px_valid ? y0_q[rd_sel_q] + COORD_W'(row) : '0;
    px_if.frame_done = release_blk && last_q[rd_sel_q];
    space_avail      = (occ_q != 2'd2);
    overflow         = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q      <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      p_q        <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      occ_q      <= occ_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      p_q        <= p_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q  <= buf_d;
    x0_q   <= x0_d;
    y0_q   <= y0_d;
    last_q <= last_d;
  end
endmodule

// File: tb/tb_block_raster_streamer.sv
// Directed bench for block_raster_streamer: capture, raster order, frame
// wrap, overflow, stalls, same-cycle capture/release and mid-stream reset.
module tb_block_raster_streamer;
  import block_raster_streamer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bw, bt;
  chan_blk_t  r_blk, g_blk, b_blk;
  logic       valid_in, px_ready, space_avail, overflow;
  int         n_cmp = 0;
  int         n_bad = 0;
  string      phase = "";

  block_raster_streamer_if #(.COORD_W(16)) bif ();
  assign bif.px_ready = px_ready;

  block_raster_streamer #(.COORD_W(16), .DIM_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .blocks_wide (bw),
    .blocks_tall (bt),
    .r           (r_blk),
    .g           (g_blk),
    .b           (b_blk),
    .valid_in    (valid_in),
    .space_avail (space_avail),
    .overflow    (overflow),
    .px_if       (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pix_obs();
    return {6'b0, bif.px_valid, bif.frame_done, bif.px_r, bif.px_g, bif.px_b,
            bif.px_x, bif.px_y};
  endfunction

  function automatic logic [63:0] pix_exp(input logic [7:0] base, input int x0,
                                          input int y0, input int p, input bit fd);
    logic [7:0] v;
    v = base + 8'(p);
    return {6'b0, 1'b1, fd, v, v + 8'h40, ~v, 16'(x0 + p % 8), 16'(y0 + p / 8)};
  endfunction

  task automatic set_block(input logic [7:0] base);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        v = base + 8'(8 * i + j);
        r_blk[i][j] = v;
        g_blk[i][j] = v + 8'h40;
        b_blk[i][j] = ~v;
      end
    end
  endtask

  task automatic send_block(input logic [7:0] base);
    set_block(base);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    valid_in = 1'b0;
    px_ready = 1'b0;
    step();
    check("rst_pix", pix_obs(), 64'h0);
    check("rst_flags", {62'b0, overflow, space_avail}, 64'h1);
    rst = 1'b1;
  endtask

  task automatic drain(input logic [7:0] base, input int x0, input int y0, input bit fd,
                       input bit stall, input bit inj, input logic [7:0] inj_base);
    int n;
    for (int p = 0; p < 64; p++) begin
      n = stall ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s < n; s++) begin
        px_ready = 1'b0;
        check("stall_hold", pix_obs(), pix_exp(base, x0, y0, p, 1'b0));
        step();
      end
      px_ready = 1'b1;
      if (inj && p == 63) begin
        set_block(inj_base);
        valid_in = 1'b1;
      end
      check("pixel", pix_obs(), pix_exp(base, x0, y0, p, fd && p == 63));
      step();
      valid_in = 1'b0;
    end
    px_ready = 1'b0;
  endtask

  initial begin
    int ox [9] = '{0, 8, 0, 8, 16, 24, 16, 24, 0};
    int oy [9] = '{0, 0, 8, 8, 0, 0, 8, 8, 0};
    bw = 8'd2;
    bt = 8'd2;
    r_blk = '0;
    g_blk = '0;
    b_blk = '0;

    phase = "reset";
    do_reset();

    phase = "single";
    send_block(8'h00);
    drain(8'h00, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("idle_after", pix_obs(), 64'h0);

    phase = "frame16";
    do_reset();
    send_block(8'h10);
    send_block(8'h20);
    check("full", {63'b0, space_avail}, 64'h0);
    drain(8'h10, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    drain(8'h20, 8, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    send_block(8'h30);
    send_block(8'h40);
    drain(8'h30, 0, 8, 1'b0, 1'b0, 1'b0, 8'h00);
    drain(8'h40, 8, 8, 1'b1, 1'b0, 1'b0, 8'h00);
    check("idle_after", pix_obs(), 64'h0);

    phase = "wide4";
    bw = 8'd4;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      send_block(8'(k * 16));
      drain(8'(k * 16), ox[k], oy[k], k == 7, 1'b0, 1'b0, 8'h00);
    end
    bw = 8'd2;

    phase = "overflow";
    do_reset();
    send_block(8'h50);
    for (int c = 0; c < 9; c++) begin
      check("hold", pix_obs(), pix_exp(8'h50, 0, 0, 0, 1'b0));
      step();
    end
    send_block(8'h60);
    check("space_full", {62'b0, overflow, space_avail}, 64'h0);
    for (int c = 0; c < 9; c++) step();
    send_block(8'h70);
    check("dropped", {62'b0, overflow, space_avail}, 64'h2);
    drain(8'h50, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    drain(8'h60, 8, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("sticky", {62'b0, overflow, space_avail}, 64'h3);
    send_block(8'h80);
    drain(8'h80, 8, 8, 1'b1, 1'b0, 1'b0, 8'h00);
    check("sticky_end", {63'b0, overflow}, 64'h1);

    phase = "stalls";
    do_reset();
    send_block(8'h90);
    send_block(8'hA0);
    drain(8'h90, 0, 0, 1'b0, 1'b1, 1'b0, 8'h00);
    drain(8'hA0, 8, 0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("idle_after", pix_obs(), 64'h0);

    phase = "same_cycle";
    do_reset();
    send_block(8'hB0);
    send_block(8'hC0);
    drain(8'hB0, 0, 0, 1'b0, 1'b0, 1'b1, 8'hD0);
    check("still_full", {62'b0, overflow, space_avail}, 64'h0);
    drain(8'hC0, 8, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    drain(8'hD0, 0, 8, 1'b0, 1'b0, 1'b0, 8'h00);
    check("no_overflow", {62'b0, overflow, space_avail}, 64'h1);

    phase = "mid_reset";
    do_reset();
    send_block(8'hE0);
    send_block(8'hF0);
    px_ready = 1'b1;
    for (int c = 0; c < 20; c++) step();
    px_ready = 1'b0;
    do_reset();
    send_block(8'h33);
    drain(8'h33, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("idle_after", pix_obs(), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
